// File: rtl/sd_spi_master.sv
// ----------------------------------------------------------------------------
// sd_spi_master
//   Byte-transfer SPI initiator for the SD interface (mode 0, SCK idle low).
//   Serial mode moves one byte as 8 SCK periods on lane 0 (MSB first).
//   Octal mode moves one byte in a single SCK period on all 8 lanes.
//   The SCK half-period is set per transfer by div (0 behaves as 1).
//   Chip select follows cs_req only while no transfer is in flight.
//
// Parameters
//   ACT_TIMEOUT : activity-stretch length in clk_sys cycles (SD_SPI_ACT_EN only)
//
// Optional feature (macro SD_SPI_ACT_EN)
//   Defined   : act pulses high while SCK toggles with the card deselected and
//               stays high for ACT_TIMEOUT cycles after the last such toggle.
//   Undefined : act is tied low and no counter exists.
//
// Ports
//   clk_sys  in   system clock
//   RESET    in   synchronous, active-high reset
//   cs_req   in   requested chip select (1 = select card)
//   start    in   single-cycle transfer request (ignored while busy)
//   tx_data  in   [7:0] byte to send, sampled at start
//   octal    in   1 = octal transfer, sampled at start
//   div      in   [7:0] SCK half-period in clk_sys cycles, sampled at start
//   busy     out  transfer in progress
//   done     out  one-cycle pulse when rx_data is valid
//   rx_data  out  [7:0] last received byte
//   sd_cs_n  out  card select, active low
//   sd_sclk  out  SPI clock
//   sd_mosi  out  [7:0] data out, lane 0 carries the serial bit
//   sd_miso  in   [7:0] data in, lane 0 carries the serial bit
//   act      out  activity indicator
// ----------------------------------------------------------------------------
module sd_spi_master #(
   parameter int ACT_TIMEOUT = 1000000
) (
   input  logic       clk_sys,
   input  logic       RESET,
   input  logic       cs_req,
   input  logic       start,
   input  logic [7:0] tx_data,
   input  logic       octal,
   input  logic [7:0] div,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       sd_cs_n,
   output logic       sd_sclk,
   output logic [7:0] sd_mosi,
   input  logic [7:0] sd_miso,
   output logic       act
);

   typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_FIN} state_t;

   state_t     r_state;
   logic       r_busy;
   logic       r_done;
   logic [7:0] r_rx;
   logic       r_cs_n;
   logic       r_sclk;
   logic [7:0] r_mosi;
   logic [7:0] r_tx;
   logic [7:0] r_shift;
   logic [7:0] r_hd;
   logic [7:0] r_phase;
   logic [2:0] r_bit;
   logic       r_octal;

   logic [7:0] w_hd;
   logic [2:0] w_bit_nxt;
   logic       w_phase_end;

   assign w_hd        = (div == 8'd0) ? 8'd1 : div;
   assign w_bit_nxt   = r_bit - 3'd1;
   assign w_phase_end = (r_phase == 8'd0);

   always_ff @(posedge clk_sys) begin
      r_done <= 1'b0;
      if (RESET) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rx    <= 8'h00;
         r_cs_n  <= 1'b1;
         r_sclk  <= 1'b0;
         r_mosi  <= 8'hFF;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cs_n <= ~cs_req;
               if (start) begin
                  r_tx    <= tx_data;
                  r_octal <= octal;
                  r_hd    <= w_hd;
                  r_phase <= w_hd - 8'd1;
                  r_bit   <= octal ? 3'd0 : 3'd7;
                  r_mosi  <= octal ? tx_data : {7'h7F, tx_data[7]};
                  r_busy  <= 1'b1;
                  r_state <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (w_phase_end) begin
                  // Rising edge: sample the card's output lanes
                  r_sclk  <= 1'b1;
                  r_phase <= r_hd - 8'd1;
                  r_shift <= r_octal ? sd_miso : {r_shift[6:0], sd_miso[0]};
                  r_state <= ST_HIGH;
               end else begin
                  r_phase <= r_phase - 8'd1;
               end
            end
            ST_HIGH: begin
               if (w_phase_end) begin
                  // Falling edge: present the next serial bit, or wrap up
                  r_sclk  <= 1'b0;
                  r_phase <= r_hd - 8'd1;
                  if (r_bit == 3'd0) begin
                     r_state <= ST_FIN;
                  end else begin
                     r_bit   <= w_bit_nxt;
                     r_mosi  <= {7'h7F, r_tx[w_bit_nxt]};
                     r_state <= ST_LOW;
                  end
               end else begin
                  r_phase <= r_phase - 8'd1;
               end
            end
            ST_FIN: begin
               r_rx    <= r_shift;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_mosi  <= 8'hFF;
               r_cs_n  <= ~cs_req;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign rx_data = r_rx;
   assign sd_cs_n = r_cs_n;
   assign sd_sclk = r_sclk;
   assign sd_mosi = r_mosi;

`ifdef SD_SPI_ACT_EN
   localparam int ACT_W = $clog2(ACT_TIMEOUT + 1);
   localparam logic [ACT_W-1:0] ACT_MAX = ACT_W'(ACT_TIMEOUT);

   logic [ACT_W-1:0] r_act_cnt;
   logic             w_sclk_tgl;

   // sclk changes on the same edge that a LOW/HIGH phase expires
   assign w_sclk_tgl = ((r_state == ST_LOW) || (r_state == ST_HIGH)) && w_phase_end;

   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         r_act_cnt <= ACT_MAX;
      end else if (w_sclk_tgl && r_cs_n) begin
         r_act_cnt <= '0;
      end else if (r_act_cnt != ACT_MAX) begin
         r_act_cnt <= r_act_cnt + 1'b1;
      end
   end

   // Counter saturates at ACT_MAX, so "not at max" equals "below timeout"
   assign act = (r_act_cnt != ACT_MAX);
`else
   // Parameter kept so instantiations are identical in both builds
   assign act = 1'b0 & (ACT_TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_sd_spi_master.sv
// ----------------------------------------------------------------------------
// tb_sd_spi_master
//   Directed bench for sd_spi_master: reset values, serial loopback, octal,
//   div=0, busy/chip-select rules, reset abort and the activity indicator.
//   Outputs are sampled on the falling edge; "after edge k" counts rising
//   edges from the one that samples start (edge 0).
// ----------------------------------------------------------------------------
module tb_sd_spi_master;

   logic       clk_sys;
   logic       RESET;
   logic       cs_req;
   logic       start;
   logic [7:0] tx_data;
   logic       octal;
   logic [7:0] div;
   logic       busy;
   logic       done;
   logic [7:0] rx_data;
   logic       sd_cs_n;
   logic       sd_sclk;
   logic [7:0] sd_mosi;
   logic [7:0] sd_miso;
   logic       act;

   logic       lb;
   logic [7:0] miso_val;

   int n_cmp;
   int n_bad;

   assign sd_miso = lb ? {miso_val[7:1], sd_mosi[0]} : miso_val;

   sd_spi_master #(.ACT_TIMEOUT(20)) dut (
      .clk_sys(clk_sys), .RESET(RESET), .cs_req(cs_req), .start(start),
      .tx_data(tx_data), .octal(octal), .div(div), .busy(busy), .done(done),
      .rx_data(rx_data), .sd_cs_n(sd_cs_n), .sd_sclk(sd_sclk),
      .sd_mosi(sd_mosi), .sd_miso(sd_miso), .act(act)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) @(negedge clk_sys);
      n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
      n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx got %h want 00", rx_data); end
      n_cmp++; if (sd_cs_n !== 1'b1)  begin n_bad++; $display("FAIL reset_cs_n got %b want 1", sd_cs_n); end
      n_cmp++; if (sd_sclk !== 1'b0)  begin n_bad++; $display("FAIL reset_sclk got %b want 0", sd_sclk); end
      n_cmp++; if (sd_mosi !== 8'hFF) begin n_bad++; $display("FAIL reset_mosi got %h want FF", sd_mosi); end
      n_cmp++; if (act !== 1'b0)      begin n_bad++; $display("FAIL reset_act got %b want 0", act); end
      RESET = 1'b0;
      @(negedge clk_sys);
   endtask

   // Runs one transfer and checks every cycle against the timing model.
   task automatic run_check(input string name, input logic [7:0] tx, input logic oct,
                            input logic [7:0] dv, input int hd, input logic [7:0] miso_v,
                            input logic [7:0] exp_rx, input int restart_at, input int csdrop_at);
      int         nb;
      int         t_done;
      int         j;
      logic [7:0] seq;
      logic       cs_start;
      logic       exp_sclk;
      logic       exp_cs;
      nb       = oct ? 1 : 8;
      t_done   = nb * 2 * hd + 1;
      seq      = 8'h00;
      miso_val = miso_v;
      lb       = !oct;
      cs_start = cs_req;
      tx_data = tx; octal = oct; div = dv; start = 1'b1;
      @(negedge clk_sys);
      // scramble the sampled inputs: the transfer must not notice
      start = 1'b0; tx_data = ~tx; octal = ~oct; div = dv + 8'd5;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_at_start got %b want 1", name, busy); end
      for (int k = 1; k <= t_done + 2; k++) begin
         start = (k == restart_at);
         if (k == csdrop_at) cs_req = 1'b0;
         @(negedge clk_sys);
         exp_sclk = (k >= hd) && (((k - hd) % (2 * hd)) < hd) && (k < nb * 2 * hd);
         exp_cs   = (k < t_done) ? ~cs_start : ~cs_req;
         n_cmp++; if (sd_sclk !== exp_sclk) begin n_bad++; $display("FAIL %s sclk k=%0d got %b want %b", name, k, sd_sclk, exp_sclk); end
         n_cmp++; if (done !== (k == t_done)) begin n_bad++; $display("FAIL %s done k=%0d got %b want %b", name, k, done, (k == t_done)); end
         n_cmp++; if (busy !== (k < t_done)) begin n_bad++; $display("FAIL %s busy k=%0d got %b want %b", name, k, busy, (k < t_done)); end
         n_cmp++; if (sd_cs_n !== exp_cs) begin n_bad++; $display("FAIL %s cs_n k=%0d got %b want %b", name, k, sd_cs_n, exp_cs); end
         n_cmp++; if (act !== 1'b0) begin n_bad++; $display("FAIL %s act k=%0d got %b want 0", name, k, act); end
         if (k >= t_done) begin
            n_cmp++; if (sd_mosi !== 8'hFF) begin n_bad++; $display("FAIL %s mosi_idle k=%0d got %h want FF", name, k, sd_mosi); end
         end else if (oct) begin
            n_cmp++; if (sd_mosi !== tx) begin n_bad++; $display("FAIL %s mosi_oct k=%0d got %h want %h", name, k, sd_mosi, tx); end
         end else begin
            n_cmp++; if (sd_mosi[7:1] !== 7'h7F) begin n_bad++; $display("FAIL %s mosi_hi k=%0d got %h want 7F", name, k, sd_mosi[7:1]); end
         end
         if (!oct && exp_sclk && (((k - hd) % (2 * hd)) == 0)) begin
            j = (k - hd) / (2 * hd);
            seq[7 - j] = sd_mosi[0];
         end
      end
      start = 1'b0;
      if (!oct) begin
         n_cmp++; if (seq !== tx) begin n_bad++; $display("FAIL %s mosi_seq got %h want %h", name, seq, tx); end
      end
      n_cmp++; if (rx_data !== exp_rx) begin n_bad++; $display("FAIL %s rx_data got %h want %h", name, rx_data, exp_rx); end
   endtask

   task automatic test_serial();
      cs_req = 1'b1;
      @(negedge clk_sys);
      n_cmp++; if (sd_cs_n !== 1'b0) begin n_bad++; $display("FAIL serial_cs_before got %b want 0", sd_cs_n); end
      // div=2: 8 periods of 2 high / 2 low, done after edge 33
      run_check("serial", 8'hA5, 1'b0, 8'd2, 2, 8'h00, 8'hA5, 0, 0);
   endtask

   task automatic test_octal();
      // single SCK period, done after edge 3
      run_check("octal", 8'h3C, 1'b1, 8'd1, 1, 8'hC3, 8'hC3, 0, 0);
   endtask

   task automatic test_div0();
      // div=0 acts as div=1 (done after edge 17); start in the FIN cycle is ignored
      run_check("div0", 8'h5A, 1'b0, 8'd0, 1, 8'h00, 8'h5A, 17, 0);
   endtask

   task automatic test_back_to_back();
      // start again at edge 5 (ignored), cs_req dropped at edge 6 (applies at FIN)
      run_check("busy_rules", 8'h96, 1'b0, 8'd1, 1, 8'h00, 8'h96, 5, 6);
   endtask

   task automatic test_reset_abort();
      cs_req = 1'b1;
      @(negedge clk_sys);
      lb = 1'b1; tx_data = 8'h81; octal = 1'b0; div = 8'd1; start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      repeat (9) @(negedge clk_sys);
      RESET = 1'b1;
      @(negedge clk_sys);
      RESET = 1'b0;
      n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
      n_cmp++; if (sd_sclk !== 1'b0)  begin n_bad++; $display("FAIL abort_sclk got %b want 0", sd_sclk); end
      n_cmp++; if (sd_cs_n !== 1'b1)  begin n_bad++; $display("FAIL abort_cs_n got %b want 1", sd_cs_n); end
      n_cmp++; if (sd_mosi !== 8'hFF) begin n_bad++; $display("FAIL abort_mosi got %h want FF", sd_mosi); end
      n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL abort_rx got %h want 00", rx_data); end
      n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL abort_done got %b want 0", done); end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_sys);
         n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done k=%0d got %b want 0", k, done); end
         n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle k=%0d got %b want 0", k, busy); end
      end
   endtask

   task automatic test_act();
      logic exp_act;
      cs_req = 1'b0;
      repeat (2) @(negedge clk_sys);
      lb = 1'b1; tx_data = 8'hF0; octal = 1'b0; div = 8'd1; start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      n_cmp++; if (act !== 1'b0) begin n_bad++; $display("FAIL act_before got %b want 0", act); end
      // toggles on edges 1..16 with card deselected: act high for edges 1..35
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk_sys);
`ifdef SD_SPI_ACT_EN
         exp_act = (k >= 1) && (k <= 35);
`else
         exp_act = 1'b0;
`endif
         n_cmp++; if (act !== exp_act) begin n_bad++; $display("FAIL act_desel k=%0d got %b want %b", k, act, exp_act); end
      end
      cs_req = 1'b1;
      repeat (2) @(negedge clk_sys);
      run_check("act_selected", 8'h0F, 1'b0, 8'd1, 1, 8'h00, 8'h0F, 0, 0);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      RESET = 1'b1; cs_req = 1'b0; start = 1'b0; tx_data = 8'h00;
      octal = 1'b0; div = 8'd1; lb = 1'b1; miso_val = 8'h00;
      test_reset();
      test_serial();
      test_octal();
      test_div0();
      test_back_to_back();
      test_reset_abort();
      test_act();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
